// File: rtl/arp_pkg.sv
// Shared types and constants for the arpeggio tone generator.
package arp_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_UP     = 2'd1,
    MODE_DOWN   = 2'd2,
    MODE_UPDOWN = 2'd3
  } arp_mode_e;

  localparam int RATIO_W = 9;

  // Divider scale per note in Q8: 256/ratio for ratios 1, 1.25, 1.5, 2, ...
  localparam logic [RATIO_W-1:0] RATIO_Q8 [0:7] = '{
    9'd256, 9'd205, 9'd171, 9'd128, 9'd102, 9'd85, 9'd64, 9'd51
  };

  function automatic logic [RATIO_W-1:0] ratio_q8(input logic [2:0] idx);
    return RATIO_Q8[idx];
  endfunction

endpackage

// File: rtl/arp_note_seq.sv
// Arpeggio note sequencer: button edge detect, enable toggle, note timer and
// HOLD/UP/DOWN/UPDOWN note ordering.
//
// mode        | meaning
// MODE_HOLD   | note parked at 0, timer idle
// MODE_UP     | 0,1,..,N-1,0,..
// MODE_DOWN   | N-1,..,0,N-1,..
// MODE_UPDOWN | bounce between 0 and N-1, endpoints played once (dir 1 = up)
module arp_note_seq
  import arp_pkg::*;
#(
  parameter int NUM_NOTES  = 4,
  parameter int NOTE_TICKS = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arp_btn,
  input  logic [1:0] mode,
  output logic [2:0] note,
  output logic       arp_en
);

  localparam int TMR_W = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(NOTE_TICKS - 1);
  localparam logic [2:0]       NOTE_LAST = 3'(NUM_NOTES - 1);
  localparam logic [2:0]       NOTE_PEN  = 3'(NUM_NOTES - 2);

  arp_mode_e mode_e;

  logic             btn_prev_q, btn_prev_d;
  logic             arp_en_q, arp_en_d;
  logic [1:0]       mode_prev_q, mode_prev_d;
  logic [TMR_W-1:0] note_tmr_q, note_tmr_d;
  logic [2:0]       note_q, note_d;
  logic             dir_q, dir_d;
  logic             rise;
  logic             restart;

  assign mode_e = arp_mode_e'(mode);
  assign note   = note_q;
  assign arp_en = arp_en_q;

  // Sequencer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_q  <= 1'b0;
      arp_en_q    <= 1'b0;
      mode_prev_q <= 2'd0;
      note_tmr_q  <= '0;
      note_q      <= 3'd0;
      dir_q       <= 1'b0;
    end else begin
      btn_prev_q  <= btn_prev_d;
      arp_en_q    <= arp_en_d;
      mode_prev_q <= mode_prev_d;
      note_tmr_q  <= note_tmr_d;
      note_q      <= note_d;
      dir_q       <= dir_d;
    end
  end

  // Next-state: idle when off or HOLD, restart beats a timer wrap, else advance.
  always_comb begin
    rise        = arp_btn & ~btn_prev_q;
    btn_prev_d  = arp_btn;
    arp_en_d    = arp_en_q ^ rise;
    mode_prev_d = mode;
    restart     = rise | (mode != mode_prev_q);
    note_tmr_d  = note_tmr_q;
    note_d      = note_q;
    dir_d       = dir_q;

    if (!arp_en_d || mode_e == MODE_HOLD) begin
      note_tmr_d = '0;
      note_d     = 3'd0;
    end else if (restart) begin
      note_tmr_d = '0;
      dir_d      = 1'b1;
      note_d     = (mode_e == MODE_DOWN) ? NOTE_LAST : 3'd0;
    end else if (note_tmr_q == TMR_LAST) begin
      note_tmr_d = '0;
      case (mode_e)
        MODE_UP:   note_d = (note_q == NOTE_LAST) ? 3'd0 : note_q + 3'd1;
        MODE_DOWN: note_d = (note_q == 3'd0) ? NOTE_LAST : note_q - 3'd1;
        MODE_UPDOWN: begin
          if (dir_q) begin
            if (note_q == NOTE_LAST) begin
              note_d = NOTE_PEN;
              dir_d  = 1'b0;
            end else begin
              note_d = note_q + 3'd1;
            end
          end else begin
            if (note_q == 3'd0) begin
              note_d = 3'd1;
              dir_d  = 1'b1;
            end else begin
              note_d = note_q - 3'd1;
            end
          end
        end
        default: note_d = 3'd0;
      endcase
    end else begin
      note_tmr_d = note_tmr_q + TMR_W'(1);
    end
  end

endmodule

// File: rtl/arp_tone_gen.sv
// Arpeggio tone generator: note-scaled phase stepping, quarter-sine fold onto
// the BRAM address and full-wave offset-binary sample reconstruction.
module arp_tone_gen
  import arp_pkg::*;
#(
  parameter int NUM_NOTES  = 4,
  parameter int NOTE_TICKS = 50_000_000,
  parameter int DIV_W      = 13,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 10
) (
  input  logic              CLK100MHZ,
  input  logic              RST,
  input  logic [DIV_W-1:0]  base_div,
  input  logic [1:0]        mode,
  input  logic              arp_btn,
  output logic [ADDR_W-1:0] lut_addr,
  input  logic [DATA_W-1:0] lut_data,
  output logic [DATA_W:0]   sample,
  output logic [2:0]        note,
  output logic              arp_en
);

  localparam int PROD_W = DIV_W + RATIO_W;
  localparam int PH_W   = ADDR_W + 2;
  localparam logic [DATA_W:0] MID = {1'b1, {DATA_W{1'b0}}};

  logic [PROD_W-1:0] prod;
  logic [DIV_W-1:0]  scaled;
  logic [DIV_W-1:0]  note_div_q, note_div_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [ADDR_W-1:0] lut_addr_q, lut_addr_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_d_q, neg_d_d;
  logic [DATA_W:0]   sample_q, sample_d;

  arp_note_seq #(
    .NUM_NOTES (NUM_NOTES),
    .NOTE_TICKS(NOTE_TICKS)
  ) u_seq (
    .clk    (CLK100MHZ),
    .rst    (RST),
    .arp_btn(arp_btn),
    .mode   (mode),
    .note   (note),
    .arp_en (arp_en)
  );

  assign lut_addr = lut_addr_q;
  assign sample   = sample_q;

  // Divider, phase and sample pipeline registers; sample idles at midscale.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      note_div_q <= '0;
      div_cnt_q  <= '0;
      phase_q    <= '0;
      lut_addr_q <= '0;
      neg_a_q    <= 1'b0;
      neg_d_q    <= 1'b0;
      sample_q   <= MID;
    end else begin
      note_div_q <= note_div_d;
      div_cnt_q  <= div_cnt_d;
      phase_q    <= phase_d;
      lut_addr_q <= lut_addr_d;
      neg_a_q    <= neg_a_d;
      neg_d_q    <= neg_d_d;
      sample_q   <= sample_d;
    end
  end

  // Note-scaled divider, phase stepping, quadrant fold and sample rebuild.
  always_comb begin
    prod       = PROD_W'(base_div) * PROD_W'(ratio_q8(note));
    scaled     = DIV_W'(prod >> 8);
    note_div_d = (scaled < DIV_W'(2)) ? DIV_W'(2) : scaled;

    // >= rather than == so a note_div that just shrank below div_cnt still steps.
    if (div_cnt_q >= note_div_q - DIV_W'(1)) begin
      div_cnt_d = '0;
      phase_d   = phase_q + PH_W'(1);
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
      phase_d   = phase_q;
    end

    lut_addr_d = phase_q[ADDR_W] ? ~phase_q[ADDR_W-1:0] : phase_q[ADDR_W-1:0];
    // neg_a lines up with lut_addr_q, neg_d with the BRAM data one clock later.
    neg_a_d    = phase_q[ADDR_W+1];
    neg_d_d    = neg_a_q;
    sample_d   = neg_d_q ? (MID - (DATA_W+1)'(1) - {1'b0, lut_data})
                         : (MID + {1'b0, lut_data});
  end

endmodule

// File: tb/tb_arp_tone_gen.sv
// Scoreboard bench for arp_tone_gen: expected address, sample and note
// sequences are queued by the stimulus and popped by change monitors.
module tb_arp_tone_gen;

  localparam int DIV_W      = 13;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 10;
  localparam int NOTE_TICKS = 100;
  localparam int NUM_NOTES  = 4;

  logic              CLK100MHZ = 1'b0;
  logic              RST       = 1'b1;
  logic [DIV_W-1:0]  base_div  = 13'd20;
  logic [1:0]        mode      = 2'd0;
  logic              arp_btn   = 1'b0;
  logic [ADDR_W-1:0] lut_addr;
  logic [DATA_W-1:0] lut_data  = '0;
  logic [DATA_W:0]   sample;
  logic [2:0]        note;
  logic              arp_en;

  always #5 CLK100MHZ = ~CLK100MHZ;

  arp_tone_gen #(
    .NUM_NOTES (NUM_NOTES),
    .NOTE_TICKS(NOTE_TICKS),
    .DIV_W     (DIV_W),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W)
  ) dut (
    .CLK100MHZ(CLK100MHZ),
    .RST      (RST),
    .base_div (base_div),
    .mode     (mode),
    .arp_btn  (arp_btn),
    .lut_addr (lut_addr),
    .lut_data (lut_data),
    .sample   (sample),
    .note     (note),
    .arp_en   (arp_en)
  );

  // BRAM stand-in: registered read, magnitude = 3*addr.
  always @(posedge CLK100MHZ) lut_data <= DATA_W'(3 * lut_addr);

  int cyc = 0;
  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  typedef struct { int val; int gap; } exp_t;
  exp_t addr_q[$];
  exp_t note_q[$];
  int   sample_q[$];
  bit   addr_mon_on = 1'b0;
  bit   sample_mon_on = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0d expected no event (cycle %0d)", name, act, cyc);
  endtask

  function automatic int exp_addr(input int p);
    int q, a;
    q = (p >> 8) & 3;
    a = p & 255;
    return (q & 1) ? 255 - a : a;
  endfunction

  function automatic int exp_sample(input int p);
    int q, d;
    q = (p >> 8) & 3;
    d = 3 * exp_addr(p);
    return (q & 2) ? 1023 - d : 1024 + d;
  endfunction

  // lut_addr monitor
  logic [ADDR_W-1:0] prev_addr = '0;
  int last_addr_cyc = 0;
  always @(negedge CLK100MHZ) begin : mon_addr
    exp_t e;
    if (addr_mon_on && lut_addr != prev_addr) begin
      if (addr_q.size() == 0) fail_now("addr_unexpected", int'(lut_addr));
      else begin
        e = addr_q.pop_front();
        chk("lut_addr", int'(lut_addr), e.val);
        if (e.gap != 0) chk("addr_gap", cyc - last_addr_cyc, e.gap);
      end
      last_addr_cyc = cyc;
    end
    prev_addr = lut_addr;
  end

  // sample monitor
  logic [DATA_W:0] prev_sample = 11'd1024;
  always @(negedge CLK100MHZ) begin : mon_sample
    int s;
    if (sample_mon_on && sample != prev_sample) begin
      if (sample_q.size() == 0) fail_now("sample_unexpected", int'(sample));
      else begin
        s = sample_q.pop_front();
        chk("sample", int'(sample), s);
      end
    end
    prev_sample = sample;
  end

  // note monitor, always active
  logic [2:0] prev_note = 3'd0;
  int last_note_cyc = 0;
  always @(negedge CLK100MHZ) begin : mon_note
    exp_t e;
    if (note != prev_note) begin
      if (note_q.size() == 0) fail_now("note_unexpected", int'(note));
      else begin
        e = note_q.pop_front();
        chk("note", int'(note), e.val);
        if (e.gap != 0) chk("note_gap", cyc - last_note_cyc, e.gap);
      end
      last_note_cyc = cyc;
    end
    prev_note = note;
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge CLK100MHZ);
  endtask

  task automatic push_note(input int v, input int g);
    note_q.push_back('{v, g});
  endtask

  task automatic wait_drained(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge CLK100MHZ);
      if (addr_q.size() == 0 && sample_q.size() == 0 && note_q.size() == 0) done = 1'b1;
    end
    if (!done) fail_now({name, "_timeout"}, note_q.size() + addr_q.size() + sample_q.size());
  endtask

  task automatic wait_note(input int v, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge CLK100MHZ);
      if (int'(note) == v) done = 1'b1;
    end
    if (!done) fail_now("wait_note_timeout", int'(note));
  endtask

  task automatic wait_addr_change(output int t);
    logic [ADDR_W-1:0] a0;
    bit done;
    a0 = lut_addr;
    done = 1'b0;
    t = -1;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge CLK100MHZ);
      if (lut_addr != a0) begin
        t = cyc;
        done = 1'b1;
      end
    end
    if (!done) fail_now("addr_change_timeout", int'(lut_addr));
  endtask

  task automatic check_step(input string name, input int gap);
    int t0, t1, t2;
    wait_addr_change(t0);
    wait_addr_change(t1);
    wait_addr_change(t2);
    chk({name, "_gap1"}, t1 - t0, gap);
    chk({name, "_gap2"}, t2 - t1, gap);
  endtask

  task automatic pulse_btn();
    arp_btn = 1'b1;
    clk_n(1);
    arp_btn = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got cycle %0d expected end of test", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pa, a_prev, s_prev, a, s;

    // reset held 3 clocks
    RST = 1'b1; base_div = 13'd20; mode = 2'd0;
    clk_n(3);
    RST = 1'b0;
    chk("rst_sample", int'(sample), 1024);
    chk("rst_lut_addr", int'(lut_addr), 0);
    chk("rst_note", int'(note), 0);
    chk("rst_arp_en", int'(arp_en), 0);

    // HOLD, base_div=20: full wave plus a bit
    pa = 0; a_prev = 0; s_prev = 1024;
    for (int p = 1; p <= 1100; p++) begin
      a = exp_addr(p);
      s = exp_sample(p);
      if (a != a_prev) begin
        addr_q.push_back('{a, (pa == 0) ? 0 : 20 * (p - pa)});
        pa = p;
        a_prev = a;
      end
      if (s != s_prev) begin
        sample_q.push_back(s);
        s_prev = s;
      end
    end
    addr_mon_on = 1'b1;
    sample_mon_on = 1'b1;
    wait_drained("hold_wave", 23000);
    addr_mon_on = 1'b0;
    sample_mon_on = 1'b0;

    // UP arpeggio
    RST = 1'b1; mode = 2'd1;
    clk_n(3);
    RST = 1'b0;
    clk_n(2);
    push_note(1, 0); push_note(2, 100); push_note(3, 100); push_note(0, 100); push_note(1, 100);
    pulse_btn();
    chk("up_arp_en", int'(arp_en), 1);
    wait_note(1, 200);
    clk_n(30);
    check_step("note1_div16", 16);
    wait_drained("up_seq", 600);

    // UPDOWN, then DOWN mid-note
    push_note(0, 0); push_note(1, 100); push_note(2, 100); push_note(3, 100);
    push_note(2, 100); push_note(1, 100); push_note(0, 100); push_note(1, 100);
    mode = 2'd3;
    wait_drained("updown_seq", 1000);
    clk_n(50);
    push_note(3, 0); push_note(2, 100); push_note(1, 100); push_note(0, 100); push_note(3, 100);
    mode = 2'd2;
    clk_n(1);
    chk("down_restart_note", int'(note), 3);
    wait_drained("down_seq", 600);

    // held button toggles once
    push_note(0, 0);
    arp_btn = 1'b1;
    clk_n(1);
    chk("held_first_toggle", int'(arp_en), 0);
    clk_n(999);
    chk("held_single_toggle", int'(arp_en), 0);
    arp_btn = 1'b0;
    clk_n(2);
    push_note(3, 0);
    pulse_btn();
    chk("rise2_arp_en", int'(arp_en), 1);
    chk("rise2_note", int'(note), 3);
    clk_n(2);
    push_note(0, 0);
    pulse_btn();
    chk("rise3_arp_en", int'(arp_en), 0);
    chk("rise3_note", int'(note), 0);
    clk_n(2);

    // clamp of note_div to 2
    RST = 1'b1; mode = 2'd0; base_div = 13'd1;
    clk_n(2);
    RST = 1'b0;
    clk_n(20);
    check_step("clamp_div1", 2);
    base_div = 13'd0;
    clk_n(10);
    check_step("clamp_div0", 2);

    // reset mid-note
    base_div = 13'd20; mode = 2'd1;
    clk_n(2);
    push_note(1, 0);
    pulse_btn();
    wait_note(1, 200);
    clk_n(50);
    push_note(0, 0);
    RST = 1'b1;
    clk_n(1);
    chk("midrst_sample", int'(sample), 1024);
    chk("midrst_lut_addr", int'(lut_addr), 0);
    chk("midrst_note", int'(note), 0);
    chk("midrst_arp_en", int'(arp_en), 0);
    clk_n(2);
    RST = 1'b0;
    clk_n(5);
    chk("post_rst_arp_en", int'(arp_en), 0);
    chk("post_rst_note", int'(note), 0);
    chk("note_queue_left", note_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
